// File: rtl/qkv_host_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : qkv_host_ctrl                                               |
// | Description : Host-side sequencer for a QKV projection engine. It streams |
// |               the input and weight memories in from s_*, enables the      |
// |               projection, then reads the output memory back through a     |
// |               2-entry FIFO onto m_*.                                      |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
// Ports
//   clk, rst (async, active-low)       clock / reset
//   start                              begin a job (sampled only in IDLE)
//   s_data/s_valid/s_ready             load stream (input words, then weights)
//   init, init_input_addr/_wen,        memory initialisation port; the wen
//   init_w_addr/_wen, mem_din          strobes are active-low
//   en / finished                      projection enable / completion
//   fin, fin_output_addr/_wen,         output-memory readback; 1-cycle read
//   out_mem_dout                       latency
//   m_data/m_valid/m_ready             result stream
//   busy, done, error                  status (done is a one-cycle pulse)
// Build option
//   QKV_HOST_TIMEOUT_EN : when defined, RUN is watched for TIMEOUT cycles; on
//   expiry error is raised (sticky until next start/reset) and the job ends
//   without draining.
module qkv_host_ctrl #(
  parameter int DW        = 128,
  parameter int IN_DEPTH  = 32,
  parameter int W_DEPTH   = 1024,
  parameter int OUT_DEPTH = 128,
  parameter int TIMEOUT   = 65535
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DW-1:0]                s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  output logic                         init,
  output logic [$clog2(IN_DEPTH)-1:0]  init_input_addr,
  output logic                         init_input_wen,
  output logic [$clog2(W_DEPTH)-1:0]   init_w_addr,
  output logic                         init_w_wen,
  output logic [DW-1:0]                mem_din,
  output logic                         en,
  input  logic                         finished,
  output logic                         fin,
  output logic [$clog2(OUT_DEPTH)-1:0] fin_output_addr,
  output logic                         fin_output_wen,
  input  logic [DW-1:0]                out_mem_dout,
  output logic [DW-1:0]                m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int WAW = $clog2(W_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int LCW = (IAW > WAW) ? IAW : WAW;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_IN = 3'd1,
    LOAD_W  = 3'd2,
    RUN     = 3'd3,
    DRAIN   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t          state_q,    state_d;
  logic [LCW-1:0]  ld_cnt_q,   ld_cnt_d;    // shared load word counter
  logic [OAW-1:0]  rd_addr_q,  rd_addr_d;   // next output-mem address to read
  logic            rd_done_q,  rd_done_d;   // every address has been issued
  logic [OAW-1:0]  pop_cnt_q,  pop_cnt_d;   // words delivered on m_*
  logic            inflight_q, inflight_d;  // read issued last cycle
  logic [DW-1:0]   fifo_q [2];
  logic [DW-1:0]   fifo_d [2];
  logic            wr_ptr_q,   wr_ptr_d;
  logic            rd_ptr_q,   rd_ptr_d;
  logic [1:0]      cnt_q,      cnt_d;

  logic            hs;
  logic            pop;
  logic            issue;

`ifdef QKV_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   run_cnt_q,  run_cnt_d;
  logic            error_q,    error_d;
  assign error = error_q;
`else
  logic            unused_cfg;
  assign unused_cfg = (TIMEOUT != 0);
  assign error      = 1'b0;
`endif

  assign fin_output_wen = 1'b1;
  assign m_valid        = (cnt_q != 2'd0);
  assign m_data         = m_valid ? fifo_q[rd_ptr_q] : '0;
  assign pop            = m_valid && m_ready;
  assign hs             = s_valid && ((state_q == LOAD_IN) || (state_q == LOAD_W));

  always_comb begin
    // outputs
    s_ready         = 1'b0;
    init            = 1'b0;
    mem_din         = '0;
    init_input_addr = '0;
    init_input_wen  = 1'b1;
    init_w_addr     = '0;
    init_w_wen      = 1'b1;
    en              = 1'b0;
    fin             = 1'b0;
    fin_output_addr = '0;
    busy            = (state_q != IDLE);
    done            = (state_q == DONE);
    // next state
    state_d    = state_q;
    ld_cnt_d   = ld_cnt_q;
    rd_addr_d  = rd_addr_q;
    rd_done_d  = rd_done_q;
    pop_cnt_d  = pop_cnt_q;
    fifo_d     = fifo_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
`ifdef QKV_HOST_TIMEOUT_EN
    run_cnt_d  = run_cnt_q;
    error_d    = error_q;
`endif

    // Occupancy after this cycle's push/pop. Counting the pop lets a new
    // read go out in the same cycle a word leaves, which keeps one word per
    // cycle flowing, while the FIFO plus in-flight read never exceeds 2.
    cnt_d = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    issue = (state_q == DRAIN) && !rd_done_q && (cnt_d < 2'd2);
    inflight_d = issue;

    if (inflight_q) begin
      fifo_d[wr_ptr_q] = out_mem_dout;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = LOAD_IN;
          ld_cnt_d  = '0;
          rd_addr_d = '0;
          rd_done_d = 1'b0;
          pop_cnt_d = '0;
          cnt_d     = 2'd0;
          wr_ptr_d  = 1'b0;
          rd_ptr_d  = 1'b0;
`ifdef QKV_HOST_TIMEOUT_EN
          run_cnt_d = '0;
          error_d   = 1'b0;
`endif
        end
      end
      LOAD_IN: begin
        s_ready         = 1'b1;
        init            = 1'b1;
        mem_din         = s_data;
        init_input_addr = ld_cnt_q[IAW-1:0];
        init_input_wen  = ~s_valid;
        if (hs) begin
          if (ld_cnt_q == LCW'(IN_DEPTH - 1)) begin
            ld_cnt_d = '0;
            state_d  = LOAD_W;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      LOAD_W: begin
        s_ready     = 1'b1;
        init        = 1'b1;
        mem_din     = s_data;
        init_w_addr = ld_cnt_q[WAW-1:0];
        init_w_wen  = ~s_valid;
        if (hs) begin
          if (ld_cnt_q == LCW'(W_DEPTH - 1)) begin
            ld_cnt_d = '0;
            state_d  = RUN;
          end else begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
      end
      RUN: begin
        en = 1'b1;
        if (finished) begin
          state_d = DRAIN;
        end
`ifdef QKV_HOST_TIMEOUT_EN
        else if (run_cnt_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          run_cnt_d = run_cnt_q + 1'b1;
        end
`endif
      end
      DRAIN: begin
        fin             = 1'b1;
        fin_output_addr = rd_addr_q;
        if (issue) begin
          // The last address is held rather than wrapped.
          if (rd_addr_q == OAW'(OUT_DEPTH - 1)) begin
            rd_done_d = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + 1'b1;
          end
        end
        if (pop) begin
          if (pop_cnt_q == OAW'(OUT_DEPTH - 1)) begin
            state_d = DONE;
          end else begin
            pop_cnt_d = pop_cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ld_cnt_q   <= '0;
      rd_addr_q  <= '0;
      rd_done_q  <= 1'b0;
      pop_cnt_q  <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
`ifdef QKV_HOST_TIMEOUT_EN
      run_cnt_q  <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_addr_q  <= rd_addr_d;
      rd_done_q  <= rd_done_d;
      pop_cnt_q  <= pop_cnt_d;
      inflight_q <= inflight_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
`ifdef QKV_HOST_TIMEOUT_EN
      run_cnt_q  <= run_cnt_d;
      error_q    <= error_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/qkv_host_ctrl.md
QKV_HOST_CTRL -- requirements
Module: qkv_host_ctrl

Interface
REQ-001 SHALL have parameters: DW=128, data word width; IN_DEPTH=32, input-mem words; W_DEPTH=1024, weight-mem words; OUT_DEPTH=128, output-mem words; TIMEOUT=65535, RUN watchdog limit in cycles.
REQ-002 SHALL have port `clk` (input, 1): single clock, rising edge.
REQ-003 SHALL have port `rst` (input, 1): asynchronous, active-low reset.
REQ-004 SHALL have port `start` (input, 1): begin a job; sampled only in IDLE.
REQ-005 SHALL have ports `s_data` (input, DW), `s_valid` (input, 1), `s_ready` (output, 1): load stream.
REQ-006 SHALL have ports `init` (output, 1), `init_input_addr` (output, 5), `init_input_wen` (output, 1, active-low write), `init_w_addr` (output, 10), `init_w_wen` (output, 1, active-low write), `mem_din` (output, DW).
REQ-007 SHALL have ports `en` (output, 1): projection enable; `finished` (input, 1): projection complete.
REQ-008 SHALL have ports `fin` (output, 1), `fin_output_addr` (output, 7), `fin_output_wen` (output, 1, constant 1), `out_mem_dout` (input, DW): output-mem readback.
REQ-009 SHALL have ports `m_data` (output, DW), `m_valid` (output, 1), `m_ready` (input, 1): result stream.
REQ-010 SHALL have ports `busy` (output, 1), `done` (output, 1, one-cycle pulse), `error` (output, 1).

Function
REQ-011 SHALL be an FSM with states IDLE, LOAD_IN, LOAD_W, RUN, DRAIN, DONE.
REQ-012 SHALL go IDLE->LOAD_IN when start=1; start is ignored in every other state.
REQ-013 SHALL, in LOAD_IN/LOAD_W, drive s_ready=1, init=1, and mem_din=s_data combinationally; s_ready=0 in all other states.
REQ-014 SHALL, on each LOAD_IN handshake, drive init_input_wen=0 in that same cycle with init_input_addr=word counter (0..31); after word 31, go to LOAD_W with the counter cleared.
REQ-015 SHALL, on each LOAD_W handshake, drive init_w_wen=0 with init_w_addr=counter (0..1023); after word 1023, go to RUN.
REQ-016 SHALL hold both wen outputs at 1 whenever there is no handshake, including s_valid=0 gaps; counters do not advance during gaps.
REQ-017 SHALL hold en=1 throughout RUN and go to DRAIN on the first cycle finished=1; en=0 in all other states.
REQ-018 SHALL hold fin=1 throughout DRAIN; SRAM read latency is 1 cycle (address in cycle N, out_mem_dout valid in cycle N+1).
REQ-019 SHALL buffer results in a 2-entry FIFO; a read is issued only when FIFO occupancy plus in-flight reads is less than 2; addresses run 0..127 in order.
REQ-020 SHALL present the FIFO head on m_data, with m_valid=1 when the FIFO is non-empty; an entry pops on m_valid&&m_ready; m_data stays stable while m_valid=1 and m_ready=0.
REQ-021 SHALL sustain 1 word/cycle when m_ready is held at 1.
REQ-022 SHALL go to DONE after word 127 is popped; DONE pulses done=1 for one cycle and then returns to IDLE.
REQ-023 SHALL drive busy=1 in every state except IDLE.
REQ-024 SHALL keep all address outputs at the counter value, and never wrap past a depth limit within a job.

Reset
REQ-025 SHALL, on rst=0 at any time including mid-job, immediately enter IDLE, clear counters and the FIFO, and drive init=en=fin=0, init_input_wen=init_w_wen=fin_output_wen=1, all addresses 0, s_ready=m_valid=busy=done=error=0, m_data=0.
REQ-026 SHALL require a new start after reset; no job resumes.

Configuration
REQ-027 SHALL, with QKV_HOST_TIMEOUT_EN defined, count cycles in RUN; if finished is not seen within TIMEOUT cycles, set error=1 (sticky until the next start or reset), skip DRAIN, and go to DONE.
REQ-028 SHALL, without QKV_HOST_TIMEOUT_EN, tie error to 0, omit the counter, and wait in RUN indefinitely.

Verification
REQ-029 SHALL cover: start, 1056 words streamed with s_valid=1, finished at RUN cycle 50 -> input wen low at addrs 0..31, weight wen low at addrs 0..1023, then en=1 until finished, then 128 words equal to mem[0..127] in order, then one done pulse.
REQ-030 SHALL cover: s_valid toggled 1/0 during load -> wen low only on handshake cycles, with no skipped or duplicated address.
REQ-031 SHALL cover: m_ready pattern 1,0,0,1 repeated in DRAIN -> no lost or duplicated word, m_data stable while stalled, at most 2 reads outstanding.
REQ-032 SHALL cover: m_ready held 1 -> 128 words in 129-130 cycles.
REQ-033 SHALL cover: rst=0 asserted at LOAD_W word 500 -> all outputs at reset values immediately; start then reloads from input address 0.
REQ-034 SHALL cover: with QKV_HOST_TIMEOUT_EN and TIMEOUT=100, finished never asserted -> error=1 and done pulse at RUN cycle 100, with no fin activity.
